// File: rtl/lfsr_prbs_sync.sv
// Purpose : PRBS lock/error controller around a self-synchronizing (feed-forward) Fibonacci LFSR descrambler.
// Latency : word T -> word_err/word_err_bits/word_err_valid in cycle T+1; locked and counters reflect word T in cycle T+2.
// Backpressure: none; data_in_valid qualifies each word, and idle cycles leave the LFSR, FSM and counters untouched.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   data_in(_valid)   received PRBS word and its qualifier
//   clear_counters    zero bit/word/lock-loss counters (FSM unaffected)
//   locked            FSM is in LOCKED
//   word_err(_bits)   registered "word had errors" flag and error popcount, qualified by word_err_valid
//   *_count           saturating counters (bit/word errors while LOCKED, LOCKED->HUNT transitions)
//
// Build option: define LFSR_PRBS_SYNC_INVERT_EN to invert data_in before the LFSR (accepts inverted PRBS).
module lfsr_prbs_sync #(
    parameter int                    LFSR_WIDTH  = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
    parameter bit                    REVERSE     = 1'b0,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    LOCK_COUNT  = 16,
    parameter int                    WINDOW      = 64,
    parameter int                    UNLOCK_ERRS = 8,
    parameter int                    CNT_WIDTH   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              data_in_valid,
    input  logic                              clear_counters,
    output logic                              locked,
    output logic                              word_err,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   word_err_bits,
    output logic                              word_err_valid,
    output logic [CNT_WIDTH-1:0]              bit_err_count,
    output logic [CNT_WIDTH-1:0]              word_err_count,
    output logic [CNT_WIDTH-1:0]              lock_loss_count
);

    localparam int BITS_W     = $clog2(DATA_WIDTH + 1);
    // Words needed before the feed-forward state holds only received data.
    localparam int WARM_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int WARM_W     = $clog2(WARM_WORDS + 1);
    localparam int CLEAN_W    = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W      = $clog2(WINDOW + 1);
    localparam int BAD_W      = $clog2(UNLOCK_ERRS + 1);
    localparam int SUM_W      = ((CNT_WIDTH > BITS_W) ? CNT_WIDTH : BITS_W) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Descrambler
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_fed;
    logic [DATA_WIDTH-1:0] lfsr_in;
    logic [DATA_WIDTH-1:0] lfsr_out_raw;
    logic [DATA_WIDTH-1:0] lfsr_out;
    logic [LFSR_WIDTH-1:0] lfsr_st;
    logic                  lfsr_fb;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [BITS_W-1:0]     pop_d;

`ifdef LFSR_PRBS_SYNC_INVERT_EN
    assign data_fed = ~data_in;
`else
    assign data_fed = data_in;
`endif

    always_comb begin
        lfsr_in = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lfsr_in[i] = REVERSE ? data_fed[DATA_WIDTH-1-i] : data_fed[i];
        end
    end

    // MSB is the first bit on the wire. Each bit is XORed with the tapped
    // history; feed-forward means the received bit itself enters the state,
    // so the descrambler resynchronizes after LFSR_WIDTH clean bits.
    always_comb begin
        lfsr_st      = lfsr_q;
        lfsr_out_raw = '0;
        lfsr_fb      = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            lfsr_fb = lfsr_st[LFSR_WIDTH-1] ^ lfsr_in[i];
            for (int j = 1; j < LFSR_WIDTH; j++) begin
                if (LFSR_POLY[j]) begin
                    lfsr_fb = lfsr_fb ^ lfsr_st[j-1];
                end
            end
            lfsr_out_raw[i] = lfsr_fb;
            lfsr_st         = {lfsr_st[LFSR_WIDTH-2:0], lfsr_in[i]};
        end
    end

    always_comb begin
        lfsr_out = '0;
        pop_d    = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lfsr_out[i] = REVERSE ? lfsr_out_raw[DATA_WIDTH-1-i] : lfsr_out_raw[i];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pop_d = pop_d + BITS_W'(lfsr_out[i]);
        end
    end

    assign lfsr_d = data_in_valid ? lfsr_st : lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers and lock FSM
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [WARM_W-1:0]   warm_q;
    logic [CLEAN_W-1:0]  clean_q;
    logic [WIN_W-1:0]    win_q;
    logic [BAD_W-1:0]    bad_q;
    logic                locked_q;
    logic                err_vld_q;
    logic                err_q;
    logic [BITS_W-1:0]   err_bits_q;
    logic                count_en;
    logic                unlock_evt;

    assign count_en   = err_vld_q && (state_q == ST_LOCKED);
    assign unlock_evt = count_en && err_q && (bad_q == BAD_W'(UNLOCK_ERRS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WARMUP;
            warm_q     <= '0;
            clean_q    <= '0;
            win_q      <= '0;
            bad_q      <= '0;
            locked_q   <= 1'b0;
            err_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            err_vld_q  <= data_in_valid;
            err_q      <= data_in_valid && (|lfsr_out);
            err_bits_q <= data_in_valid ? pop_d : '0;

            if (err_vld_q) begin
                case (state_q)
                    ST_WARMUP: begin
                        if (warm_q == WARM_W'(WARM_WORDS - 1)) begin
                            state_q <= ST_HUNT;
                            clean_q <= '0;
                        end else begin
                            warm_q <= warm_q + WARM_W'(1);
                        end
                    end
                    ST_HUNT: begin
                        if (err_q) begin
                            clean_q <= '0;
                        end else if (clean_q == CLEAN_W'(LOCK_COUNT - 1)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            win_q    <= '0;
                            bad_q    <= '0;
                        end else begin
                            clean_q <= clean_q + CLEAN_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Unlock takes priority over the window rollover.
                        if (unlock_evt) begin
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                            clean_q  <= '0;
                        end else if (win_q == WIN_W'(WINDOW - 1)) begin
                            win_q <= '0;
                            bad_q <= '0;
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                            if (err_q) begin
                                bad_q <= bad_q + BAD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_WARMUP;
                        warm_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] bit_cnt_q,  bit_cnt_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
    logic [SUM_W-1:0]     bit_sum;

    // Word popcount can exceed a narrow counter, so add in a wider domain.
    assign bit_sum = SUM_W'(bit_cnt_q) + SUM_W'(err_bits_q);

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        loss_cnt_d = loss_cnt_q;
        if (clear_counters) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            loss_cnt_d = '0;
        end else begin
            if (count_en) begin
                bit_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
            end
            if (count_en && err_q && (word_cnt_q != CNT_MAX)) begin
                word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            end
            if (unlock_evt && (loss_cnt_q != CNT_MAX)) begin
                loss_cnt_d = loss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            loss_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign locked          = locked_q;
    assign word_err        = err_q;
    assign word_err_bits   = err_bits_q;
    assign word_err_valid  = err_vld_q;
    assign bit_err_count   = bit_cnt_q;
    assign word_err_count  = word_cnt_q;
    assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_sync.sv
// Bench for lfsr_prbs_sync: PRBS31 stream generator, bit-stream reference model, scenario and random phases.
module tb_lfsr_prbs_sync;

    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int CMAX  = 15;
    localparam int WARM  = (31 + DW - 1) / DW;
    localparam int LOCKN = 16;
    localparam int WIN   = 64;
    localparam int UNL   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          clear_counters;
    logic          locked;
    logic          word_err;
    logic [5:0]    word_err_bits;
    logic          word_err_valid;
    logic [CW-1:0] bit_err_count;
    logic [CW-1:0] word_err_count;
    logic [CW-1:0] lock_loss_count;

    lfsr_prbs_sync #(.CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .clear_counters  (clear_counters),
        .locked          (locked),
        .word_err        (word_err),
        .word_err_bits   (word_err_bits),
        .word_err_valid  (word_err_valid),
        .bit_err_count   (bit_err_count),
        .word_err_count  (word_err_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // PRBS31 source: b[n] = b[n-31] ^ b[n-28], history seeded with ones.
    bit gen_hist[$];

    task automatic prbs_word(output logic [DW-1:0] w);
        bit b;
        for (int i = DW - 1; i >= 0; i--) begin
            b = gen_hist[0] ^ gen_hist[3];
            void'(gen_hist.pop_front());
            gen_hist.push_back(b);
            w[i] = b;
        end
    endtask

    // Reference model: received-bit history and the lock rules as plain counts.
    bit rx_hist[$];
    int m_mode;            // 0 warm-up, 1 hunting, 2 locked
    int m_warm, m_run, m_win, m_bad;
    int m_bit, m_word, m_loss;
    bit m_s1v, m_s1e;
    int m_s1b;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        rx_hist.delete();
        for (int i = 0; i < 31; i++) rx_hist.push_back(1'b1);
        m_mode = 0; m_warm = 0; m_run = 0; m_win = 0; m_bad = 0;
        m_bit = 0; m_word = 0; m_loss = 0;
        m_s1v = 1'b0; m_s1e = 1'b0; m_s1b = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [DW-1:0] d, input bit clr);
        bit was_locked;
        bit unlock;
        int pop;
        bit rb, e;
        if (r) begin
            model_reset();
            return;
        end
        was_locked = m_s1v && (m_mode == 2);
        unlock = 1'b0;
        if (m_s1v) begin
            if (m_mode == 0) begin
                m_warm++;
                if (m_warm == WARM) begin m_mode = 1; m_run = 0; end
            end else if (m_mode == 1) begin
                m_run = m_s1e ? 0 : m_run + 1;
                if (m_run == LOCKN) begin m_mode = 2; m_win = 0; m_bad = 0; end
            end else begin
                m_win++;
                if (m_s1e) m_bad++;
                if (m_bad == UNL) begin
                    m_mode = 1; m_run = 0; unlock = 1'b1;
                end else if (m_win == WIN) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end
        if (clr) begin
            m_bit = 0; m_word = 0; m_loss = 0;
        end else if (was_locked) begin
            m_bit = sat(m_bit + m_s1b);
            if (m_s1e) m_word = sat(m_word + 1);
            if (unlock) m_loss = sat(m_loss + 1);
        end
        if (v) begin
            pop = 0;
            for (int i = DW - 1; i >= 0; i--) begin
`ifdef LFSR_PRBS_SYNC_INVERT_EN
                rb = ~d[i];
`else
                rb = d[i];
`endif
                e = rb ^ rx_hist[0] ^ rx_hist[3];
                pop += int'(e);
                void'(rx_hist.pop_front());
                rx_hist.push_back(rb);
            end
            m_s1v = 1'b1; m_s1b = pop; m_s1e = (pop != 0);
        end else begin
            m_s1v = 1'b0; m_s1e = 1'b0; m_s1b = 0;
        end
    endtask

    // Lock-point bookkeeping: valid words driven before the edge at which locked rises.
    int  nv = 0;
    int  lock_nv = -1;
    bit  prev_locked = 1'b0;

    task automatic step(input bit r, input bit v, input logic [DW-1:0] d, input bit clr);
        int nv_before;
        @(negedge clk);
        rst = r; data_in_valid = v; data_in = d; clear_counters = clr;
        @(posedge clk);
        model_step(r, v, d, clr);
        nv_before = nv;
        if (r) begin
            nv = 0; lock_nv = -1;
        end else if (v) begin
            nv++;
        end
        #1;
        check("locked", 64'(locked), 64'(m_mode == 2));
        check("word_err_valid", 64'(word_err_valid), 64'(m_s1v));
        check("word_err", 64'(word_err), 64'(m_s1e));
        if (m_s1v) check("word_err_bits", 64'(word_err_bits), 64'(m_s1b));
        check("bit_err_count", 64'(bit_err_count), 64'(m_bit));
        check("word_err_count", 64'(word_err_count), 64'(m_word));
        check("lock_loss_count", 64'(lock_loss_count), 64'(m_loss));
        if (!r && locked && !prev_locked && lock_nv < 0) lock_nv = nv_before;
        prev_locked = r ? 1'b0 : locked;
    endtask

    task automatic clean_words(input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            prbs_word(w);
            step(1'b0, 1'b1, w, 1'b0);
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        int            base;
        bit            v;
        rst = 1'b1; data_in_valid = 1'b0; data_in = '0; clear_counters = 1'b0;
        for (int i = 0; i < 31; i++) gen_hist.push_back(1'b1);
        model_reset();

        // Reset state and straight lock on a clean stream.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        clean_words(200);
        check("s1_lock_point", 64'(lock_nv), 64'(WARM + LOCKN));
        check("s1_locked", 64'(locked), 64'd1);
        check("s1_bit_cnt", 64'(bit_err_count), 64'd0);

        // Two flipped bits in one word: FF taps replicate each error twice.
        base = int'(bit_err_count);
        prbs_word(w);
        step(1'b0, 1'b1, w ^ 32'h21, 1'b0);
        check("s2_word_bits", 64'(word_err_bits), 64'd2);
        clean_words(4);
        check("s2_bit_cnt", 64'(int'(bit_err_count) - base), 64'd6);
        check("s2_locked", 64'(locked), 64'd1);

        // Eight errored words after a fresh lock force unlock.
        step(1'b1, 1'b0, '0, 1'b0);
        clean_words(20);
        for (int k = 0; k < 8; k++) begin
            prbs_word(w);
            step(1'b0, 1'b1, w ^ 32'h1, 1'b0);
        end
        check("s3_locked_before", 64'(locked), 64'd1);
        clean_words(1);
        check("s3_unlocked", 64'(locked), 64'd0);
        check("s3_loss_cnt", 64'(lock_loss_count), 64'd1);
        check("s3_bit_sat", 64'(bit_err_count), 64'(CMAX));
        check("s3_word_cnt", 64'(word_err_count), 64'd8);
        clean_words(20);
        check("s3_relocked", 64'(locked), 64'd1);

        // Clear on the same edge that consumes an errored word.
        prbs_word(w);
        step(1'b0, 1'b1, w ^ 32'h80000000, 1'b0);
        prbs_word(w);
        step(1'b0, 1'b1, w, 1'b1);
        check("s5_clr_bit", 64'(bit_err_count), 64'd0);
        check("s5_clr_word", 64'(word_err_count), 64'd0);
        check("s5_clr_loss", 64'(lock_loss_count), 64'd0);
        clean_words(5);

        // Reset while locked.
        step(1'b1, 1'b0, '0, 1'b0);
        check("s6_rst_locked", 64'(locked), 64'd0);
        check("s6_rst_word_cnt", 64'(word_err_count), 64'd0);

        // Random gaps on a clean stream: lock point counted in valid words is unchanged.
        for (int k = 0; k < 120; k++) begin
            v = ($urandom_range(0, 1) == 1);
            if (v) prbs_word(w); else w = $urandom;
            step(1'b0, v, w, 1'b0);
        end
        check("s4_lock_point", 64'(lock_nv), 64'(WARM + LOCKN));
        check("s4_word_cnt", 64'(word_err_count), 64'd0);

        // Inverted PRBS31.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 100; k++) begin
            prbs_word(w);
            step(1'b0, 1'b1, ~w, 1'b0);
        end
`ifdef LFSR_PRBS_SYNC_INVERT_EN
        check("s6_inv_lock_point", 64'(lock_nv), 64'(WARM + LOCKN));
`else
        check("s6_inv_no_lock", 64'(locked), 64'd0);
`endif

        // Random phase: gaps, sparse bit errors, bursts, clears and occasional resets.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            bit r, clr;
            r   = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            if (v) begin
                prbs_word(w);
`ifdef LFSR_PRBS_SYNC_INVERT_EN
                w = ~w;
`endif
                if ($urandom_range(0, 19) == 0) w[$urandom_range(0, DW - 1)] ^= 1'b1;
                if ($urandom_range(0, 149) == 0) begin
                    for (int b = 0; b < 12; b++) begin
                        prbs_word(w);
                        w = w ^ $urandom;
                        step(1'b0, 1'b1, w, 1'b0);
                    end
                end
            end else begin
                w = $urandom;
            end
            step(r, v, w, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
